// File: rtl/div_issue_queue.sv
// ----------------------------------------------------------------------------
// div_issue_queue
//
// Request buffer in front of a combinational restoring divider. Division
// requests are queued in a DEPTH-entry FIFO. The head operands drive the
// divider, and the divider's answer is captured into a result register that
// has a valid/ready handshake. A zero divisor is caught here: the divider
// output for that entry is ignored and a fixed result is captured instead.
//
// Parameters
//   WIDTH          operand/result width (must match the divider)
//   DEPTH          FIFO entries, power of two, >= 2
//
// Ports
//   clk            rising-edge clock
//   arst_n         asynchronous reset, active low
//   in_valid/in_ready/in_a/in_b        request handshake and operands
//   div_a/div_b                        head operands to the divider (0 when empty)
//   div_quotient/div_remainder         combinational divider answer
//   out_valid/out_ready                result handshake
//   out_quotient/out_remainder         registered result
//   out_div_zero                       result came from a zero divisor
//   count                              FIFO occupancy
//
// Optional feature (macro DIV_QUEUE_STATS_EN)
//   stat_ops       16-bit wrapping count of completed captures
//   stat_div_zero  16-bit wrapping count of divide-by-zero captures
// ----------------------------------------------------------------------------
module div_issue_queue #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic [CW-1:0]    count
`ifdef DIV_QUEUE_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_div_zero
`endif
);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             empty;
    logic             push;
    logic             pop;
    logic             head_div_zero;
    logic [WIDTH-1:0] cap_quotient;
    logic [WIDTH-1:0] cap_remainder;

    // in_ready comes only from registered occupancy, so a pop in the same
    // cycle never opens a slot for a push while the FIFO is full.
    assign empty    = (count == '0);
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!out_valid || out_ready);

    assign div_a = empty ? '0 : mem_a[rd_ptr];
    assign div_b = empty ? '0 : mem_b[rd_ptr];

    // Divide-by-zero overrides whatever the divider produces for the head.
    assign head_div_zero = (div_b == '0);
    assign cap_quotient  = head_div_zero ? '1    : div_quotient;
    assign cap_remainder = head_div_zero ? div_a : div_remainder;

    // NOTE: the storage array has no reset; entries are only read after a
    // push has written them, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, regardless of block order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_div_zero  <= 1'b0;
        end else if (pop) begin
            out_valid     <= 1'b1;
            out_quotient  <= cap_quotient;
            out_remainder <= cap_remainder;
            out_div_zero  <= head_div_zero;
        end else if (out_valid && out_ready) begin
            // Result consumed with nothing behind it; data holds its value.
            out_valid <= 1'b0;
        end
    end

`ifdef DIV_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_ops      <= '0;
            stat_div_zero <= '0;
        end else if (pop) begin
            stat_ops <= stat_ops + 16'd1;
            if (head_div_zero) stat_div_zero <= stat_div_zero + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_issue_queue.sv
`timescale 1ns/1ps
module tb_div_issue_queue;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             arst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [WIDTH-1:0] div_a, div_b;
    logic [WIDTH-1:0] div_quotient, div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient, out_remainder;
    logic             out_div_zero;
    logic [CW-1:0]    count;
`ifdef DIV_QUEUE_STATS_EN
    logic [15:0]      stat_ops, stat_div_zero;
`endif

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    // Stand-in for the combinational divider. On a zero divisor it emits
    // junk so that any failure to override it is visible.
    assign div_quotient  = (div_b == 0) ? 4'h0 : div_a / div_b;
    assign div_remainder = (div_b == 0) ? 4'h3 : div_a % div_b;

    div_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_div_zero  (out_div_zero),
        .count         (count)
`ifdef DIV_QUEUE_STATS_EN
        ,
        .stat_ops      (stat_ops),
        .stat_div_zero (stat_div_zero)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of pending requests plus the expected
    // contents of the result register, advanced once per clock edge.
    // ------------------------------------------------------------------
    typedef struct packed { logic [3:0] a; logic [3:0] b; } req_t;
    req_t mq[$];
    logic m_valid;
    logic [3:0] m_q, m_r;
    logic m_z;
    int   m_ops, m_zero;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mq.delete();
            m_valid = 0; m_q = 0; m_r = 0; m_z = 0;
            m_ops = 0; m_zero = 0;
        end else begin
            int  sz;
            bit  do_pop, do_push;
            sz      = mq.size();
            do_pop  = (sz > 0) && (!m_valid || out_ready);
            do_push = in_valid && (sz < DEPTH);
            if (do_pop) begin
                req_t h;
                h = mq.pop_front();
                if (h.b == 0) begin
                    m_q = 4'hF; m_r = h.a; m_z = 1; m_zero = (m_zero + 1) % 65536;
                end else begin
                    m_q = h.a / h.b; m_r = h.a % h.b; m_z = 0;
                end
                m_ops   = (m_ops + 1) % 65536;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (do_push) mq.push_back('{a: in_a, b: in_b});
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (arst_n) begin
            check("count",     32'(count), 32'(mq.size()));
            check("in_ready",  32'(in_ready), 32'(mq.size() < DEPTH));
            check("div_a",     32'(div_a), mq.size() > 0 ? 32'(mq[0].a) : 0);
            check("div_b",     32'(div_b), mq.size() > 0 ? 32'(mq[0].b) : 0);
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_q",     32'(out_quotient), 32'(m_q));
            check("out_r",     32'(out_remainder), 32'(m_r));
            check("out_z",     32'(out_div_zero), 32'(m_z));
`ifdef DIV_QUEUE_STATS_EN
            check("stat_ops",  32'(stat_ops), 32'(m_ops));
            check("stat_zero", 32'(stat_div_zero), 32'(m_zero));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 arst_n = 0;
        #4 arst_n = 1;
        in_valid = 0;
    endtask

    // Directed tables for streaming and backpressure.
    logic [3:0] st_a [4] = '{15, 9, 0, 8};
    logic [3:0] st_b [4] = '{4, 9, 5, 1};
    logic [3:0] st_q [4] = '{3, 1, 0, 8};
    logic [3:0] st_r [4] = '{3, 0, 0, 0};

    logic [3:0] bp_a [5] = '{10, 14, 5, 12, 1};
    logic [3:0] bp_b [5] = '{3, 2, 0, 5, 1};
    logic [3:0] bp_q [5] = '{3, 7, 15, 2, 1};
    logic [3:0] bp_r [5] = '{1, 0, 5, 2, 0};
    logic       bp_z [5] = '{0, 0, 1, 0, 0};

    initial begin
        int pushes;
        arst_n = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        #25 arst_n = 1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count",     32'(count), 0);
        check("rst_in_ready",  32'(in_ready), 1);
        check("rst_q",         32'(out_quotient), 0);

        // Single op: 13 / 3.
        out_ready = 1; in_valid = 1; in_a = 13; in_b = 3;
        step();
        in_valid = 0;
        check("single_not_yet", 32'(out_valid), 0);
        step();
        check("single_valid", 32'(out_valid), 1);
        check("single_q",     32'(out_quotient), 4);
        check("single_r",     32'(out_remainder), 1);
        check("single_z",     32'(out_div_zero), 0);
        check("single_count", 32'(count), 0);
        step();

        // Divide by zero: 7 / 0.
        do_reset();
        out_ready = 1; in_valid = 1; in_a = 7; in_b = 0;
        step();
        in_valid = 0;
        step();
        check("dz_q", 32'(out_quotient), 32'hF);
        check("dz_r", 32'(out_remainder), 7);
        check("dz_z", 32'(out_div_zero), 1);
`ifdef DIV_QUEUE_STATS_EN
        check("dz_stat_zero", 32'(stat_div_zero), 1);
        check("dz_stat_ops",  32'(stat_ops), 1);
`endif
        step();

        // Streaming at full throughput.
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            if (i < 4) begin in_a = st_a[i]; in_b = st_b[i]; end
            step();
            check("stream_count_le1", 32'(count <= 1), 1);
            if (i > 0) begin
                check("stream_valid", 32'(out_valid), 1);
                check("stream_q", 32'(out_quotient), 32'(st_q[i-1]));
                check("stream_r", 32'(out_remainder), 32'(st_r[i-1]));
            end
        end
        in_valid = 0;
        step();

        // Backpressure: five pushes with the consumer stalled.
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_a = bp_a[i]; in_b = bp_b[i];
            step();
        end
        in_valid = 0;
        check("bp_count",    32'(count), 4);
        check("bp_in_ready", 32'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_q",     32'(out_quotient), 32'(bp_q[0]));
            check("bp_hold_r",     32'(out_remainder), 32'(bp_r[0]));
            if (k < 2) step();
        end
        out_ready = 1;
        for (int i = 1; i < 5; i++) begin
            step();
            check("bp_drain_q", 32'(out_quotient), 32'(bp_q[i]));
            check("bp_drain_r", 32'(out_remainder), 32'(bp_r[i]));
            check("bp_drain_z", 32'(out_div_zero), 32'(bp_z[i]));
        end
        step();
        check("bp_drained", 32'(out_valid), 0);

        // Reset mid-operation.
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_a = 4'(i + 6); in_b = 2;
            step();
        end
        in_valid = 0;
        check("mid_pre_valid", 32'(out_valid), 1);
        check("mid_pre_count", 32'(count), 3);
        #2 arst_n = 0;
        #2;
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_count",     32'(count), 0);
        check("mid_in_ready",  32'(in_ready), 1);
        #2 arst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_stale", 32'(out_valid), 0);
        end

        // Wrap: many pushes with random backpressure.
        pushes = 0;
        for (int i = 0; i < 300 && pushes < 3 * DEPTH + 2; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 4'($urandom_range(0, 15));
            in_b      = 4'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 1) != 0;
            if (in_valid && in_ready) pushes++;
            step();
        end
        check("wrap_pushes", 32'(pushes >= 3 * DEPTH), 1);
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < DEPTH + 3; i++) step();
        check("wrap_empty", 32'(count), 0);
        check("wrap_idle",  32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
